shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 15 +
 rtl/shift_arbiter_if.sv | 37 +++
 rtl/shift_arbiter_shift_core.sv | 39 +++
 rtl/shift_arbiter.sv | 94 +++++++++
 tb/tb_shift_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared CPU constants for the shift unit: op encodings and datapath widths.
// Used by the ALU, the decoder and the shared shift arbiter.
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SRL  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two-requester shift request/response bundle.
// The master drives requests and response drain; the slave is the arbiter.
interface shift_arbiter_if import shift_arbiter_pkg::*; ();

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [SHAMT_W-1:0] req0_shamt;
    shift_op_e         req0_op;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_data;
    logic              resp0_ready;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [SHAMT_W-1:0] req1_shamt;
    shift_op_e         req1_op;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_data;
    logic              resp1_ready;

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op, resp0_ready,
        output req1_valid, req1_data, req1_shamt, req1_op, resp1_ready,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data
    );

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op, resp0_ready,
        input  req1_valid, req1_data, req1_shamt, req1_op, resp1_ready,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data
    );

endinterface

// File: rtl/shift_arbiter_shift_core.sv
// Combinational barrel shifter built as 16/8/4/2/1 stages.
// Left shifts zero-fill; right shifts fill with zero or the sign bit.
module shift_core import shift_arbiter_pkg::*; (
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_e          op,
    output logic [DATA_W-1:0]  result
);

    logic              left;
    logic              fill;
    logic [DATA_W-1:0] s16;
    logic [DATA_W-1:0] s8;
    logic [DATA_W-1:0] s4;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s1;

    assign left = (op == OP_SLL);
    assign fill = (op == OP_SRA) & operand[31];

    assign s16 = !shamt[4] ? operand :
                 left ? {operand[15:0], 16'b0} :
                        {{16{fill}}, operand[31:16]};
    assign s8  = !shamt[3] ? s16 :
                 left ? {s16[23:0], 8'b0} :
                        {{8{fill}}, s16[31:8]};
    assign s4  = !shamt[2] ? s8 :
                 left ? {s8[27:0], 4'b0} :
                        {{4{fill}}, s8[31:4]};
    assign s2  = !shamt[1] ? s4 :
                 left ? {s4[29:0], 2'b0} :
                        {{2{fill}}, s4[31:2]};
    assign s1  = !shamt[0] ? s2 :
                 left ? {s2[30:0], 1'b0} :
                        {fill, s2[31:1]};

    assign result = (op == OP_PASS) ? operand : s1;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift core between two requesters.
// Each requester owns a one-entry response register with valid/ready drain.
module shift_arbiter import shift_arbiter_pkg::*; #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    shift_arbiter_if.slave bus
);

    logic              last_q, last_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0] resp0_data_q, resp0_data_d;
    logic [DATA_W-1:0] resp1_data_q, resp1_data_d;

    logic              elig0, elig1;
    logic              grant0, grant1;
    logic [DATA_W-1:0] core_operand;
    logic [SHAMT_W-1:0] core_shamt;
    shift_op_e         core_op;
    logic [DATA_W-1:0] core_result;

    // last_q names the requester granted most recently; the other wins ties
    always_comb begin
        elig0  = bus.req0_valid && !reset &&
                 (!resp0_valid_q || bus.resp0_ready);
        elig1  = bus.req1_valid && !reset &&
                 (!resp1_valid_q || bus.resp1_ready);
        grant0 = elig0 && (!elig1 || last_q);
        grant1 = elig1 && !grant0;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        core_operand = bus.req0_data;
        core_shamt   = bus.req0_shamt;
        core_op      = bus.req0_op;
        if (grant1) begin
            core_operand = bus.req1_data;
            core_shamt   = bus.req1_shamt;
            core_op      = bus.req1_op;
        end
    end

    shift_core u_core (
        .operand (core_operand),
        .shamt   (core_shamt),
        .op      (core_op),
        .result  (core_result)
    );

    always_comb begin
        last_d        = last_q;
        resp0_valid_d = resp0_valid_q && !bus.resp0_ready;
        resp1_valid_d = resp1_valid_q && !bus.resp1_ready;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;
        if (grant0) begin
            last_d        = 1'b0;
            resp0_valid_d = 1'b1;
            resp0_data_d  = core_result;
        end
        if (grant1) begin
            last_d        = 1'b1;
            resp1_valid_d = 1'b1;
            resp1_data_d  = core_result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q        <= ~RR_INIT;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
        end else begin
            last_q        <= last_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
        end
    end

    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp0_data  = resp0_data_q;
    assign bus.resp1_data  = resp1_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: reference model plus directed scenarios.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_arbiter_if bus ();

    shift_arbiter #(.RR_INIT(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // reference model state: pending slot per requester, tie winner
    logic        m_v[2]  = '{1'b0, 1'b0};
    logic [31:0] m_d[2]  = '{32'h0, 32'h0};
    int          m_prio  = 0;

    function automatic logic [31:0] ref_shift(logic [31:0] d,
                                              logic [4:0] sh,
                                              shift_op_e op);
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            OP_SRA:  return 32'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    // returns index granted, or -1
    function automatic int model_grant();
        bit e0, e1;
        e0 = bus.req0_valid && (!m_v[0] || bus.resp0_ready);
        e1 = bus.req1_valid && (!m_v[1] || bus.resp1_ready);
        if (e0 && e1) return m_prio;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_v[0] = 1'b0; m_v[1] = 1'b0;
            m_d[0] = '0;   m_d[1] = '0;
            m_prio = 0;
        end else begin
            int g;
            g = model_grant();
            if (bus.resp0_ready) m_v[0] = 1'b0;
            if (bus.resp1_ready) m_v[1] = 1'b0;
            if (g == 0) begin
                m_v[0] = 1'b1;
                m_d[0] = ref_shift(bus.req0_data, bus.req0_shamt, bus.req0_op);
                m_prio = 1;
            end else if (g == 1) begin
                m_v[1] = 1'b1;
                m_d[1] = ref_shift(bus.req1_data, bus.req1_shamt, bus.req1_op);
                m_prio = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("m_rst_rdy0", 32'(bus.req0_ready), 32'd0);
            chk("m_rst_rdy1", 32'(bus.req1_ready), 32'd0);
            chk("m_rst_v0", 32'(bus.resp0_valid), 32'd0);
            chk("m_rst_v1", 32'(bus.resp1_valid), 32'd0);
        end else begin
            int g;
            g = model_grant();
            chk("m_rdy0", 32'(bus.req0_ready), 32'(g == 0));
            chk("m_rdy1", 32'(bus.req1_ready), 32'(g == 1));
            chk("m_v0", 32'(bus.resp0_valid), 32'(m_v[0]));
            chk("m_v1", 32'(bus.resp1_valid), 32'(m_v[1]));
            chk("m_d0", bus.resp0_data, m_d[0]);
            chk("m_d1", bus.resp1_data, m_d[1]);
        end
    end

    task automatic idle();
        bus.req0_valid = 0; bus.req0_data = '0;
        bus.req0_shamt = '0; bus.req0_op = OP_SLL;
        bus.req1_valid = 0; bus.req1_data = '0;
        bus.req1_shamt = '0; bus.req1_op = OP_SLL;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
    endtask

    task automatic drv0(shift_op_e op, logic [31:0] d, logic [4:0] sh);
        bus.req0_valid = 1; bus.req0_op = op;
        bus.req0_data = d;  bus.req0_shamt = sh;
    endtask

    task automatic drv1(shift_op_e op, logic [31:0] d, logic [4:0] sh);
        bus.req1_valid = 1; bus.req1_op = op;
        bus.req1_data = d;  bus.req1_shamt = sh;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        shift_op_e   op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[2] = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[3] = '{OP_SLL, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
        vecs[4] = '{OP_SRL, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF};
        vecs[5] = '{OP_SRA, 32'h4000_0000, 5'd30, 32'h0000_0001};
        vecs[6] = '{OP_SLL, 32'hABCD_1234, 5'd0,  32'hABCD_1234};
        vecs[7] = '{OP_SRL, 32'hABCD_1234, 5'd0,  32'hABCD_1234};

        // reset holds ready low even with a valid request
        idle();
        drv0(OP_SRA, 32'h8000_0000, 5'd4);
        @(negedge clock);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_data0", bus.resp0_data, 32'd0);
        chk("rst_data1", bus.resp1_data, 32'd0);
        @(posedge clock);
        #1 reset = 0;

        // first grant on the first edge after release
        @(negedge clock);
        chk("sra_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        idle();
        @(negedge clock);
        chk("sra_valid", 32'(bus.resp0_valid), 32'd1);
        chk("sra_data", bus.resp0_data, 32'hF800_0000);
        tick();

        // alternation from RR_INIT=0
        reset = 1;
        #2 reset = 0;
        drv0(OP_SRL, 32'hF000_0000, 5'd4);
        drv1(OP_SLL, 32'h0000_0001, 5'd31);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rr_ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
            chk("rr_ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
            tick();
        end
        @(negedge clock);
        chk("rr_data0", bus.resp0_data, 32'h0F00_0000);
        chk("rr_data1", bus.resp1_data, 32'h8000_0000);
        tick();
        idle();
        tick();

        // blocked slot 0: requester 1 keeps flowing, slot 0 holds
        drv0(OP_SRL, 32'hF000_0000, 5'd4);
        bus.resp0_ready = 0;
        @(negedge clock);
        chk("blk_first", 32'(bus.req0_ready), 32'd1);
        tick();
        drv0(OP_PASS, 32'h1234_5678, 5'd0);
        drv1(OP_SLL, 32'h0000_0001, 5'd31);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("blk_ready0", 32'(bus.req0_ready), 32'd0);
            chk("blk_ready1", 32'(bus.req1_ready), 32'd1);
            chk("blk_hold", bus.resp0_data, 32'h0F00_0000);
            tick();
        end

        // drain and refill in the same cycle
        bus.req1_valid = 0;
        bus.resp0_ready = 1;
        drv0(OP_SRA, 32'h7FFF_FFFF, 5'd31);
        @(negedge clock);
        chk("b2b_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 0;
        @(negedge clock);
        chk("b2b_valid", 32'(bus.resp0_valid), 32'd1);
        chk("b2b_data", bus.resp0_data, 32'h0000_0000);
        tick();

        // pass-through and zero shift leave the operand alone
        drv0(OP_PASS, 32'hDEAD_BEEF, 5'd17);
        tick();
        drv0(OP_SLL, 32'h0000_0001, 5'd3);
        @(negedge clock);
        chk("pass17", bus.resp0_data, 32'hDEAD_BEEF);
        tick();
        bus.req0_valid = 0;
        drv1(OP_SRA, 32'hDEAD_BEEF, 5'd0);
        @(negedge clock);
        chk("sll3", bus.resp0_data, 32'h0000_0008);
        tick();
        idle();
        @(negedge clock);
        chk("sra0", bus.resp1_data, 32'hDEAD_BEEF);
        tick();

        // shift boundary table
        foreach (vecs[i]) begin
            drv0(vecs[i].op, vecs[i].d, vecs[i].sh);
            tick();
            bus.req0_valid = 0;
            @(negedge clock);
            chk("vec", bus.resp0_data, vecs[i].exp);
        end
        tick();

        // async reset with both responses pending
        idle();
        bus.resp0_ready = 0;
        bus.resp1_ready = 0;
        drv0(OP_PASS, 32'h1111_1111, 5'd0);
        drv1(OP_PASS, 32'h2222_2222, 5'd0);
        tick();
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        @(negedge clock);
        chk("pend_v0", 32'(bus.resp0_valid), 32'd1);
        chk("pend_v1", 32'(bus.resp1_valid), 32'd1);
        #2 reset = 1;
        #1;
        chk("arst_v0", 32'(bus.resp0_valid), 32'd0);
        chk("arst_v1", 32'(bus.resp1_valid), 32'd0);
        chk("arst_d0", bus.resp0_data, 32'd0);
        @(posedge clock);
        #1 reset = 0;
        bus.resp0_ready = 1;
        bus.resp1_ready = 1;
        repeat (3) begin
            @(negedge clock);
            chk("post_v0", 32'(bus.resp0_valid), 32'd0);
            chk("post_v1", 32'(bus.resp1_valid), 32'd0);
        end
        tick();
        drv1(OP_PASS, 32'h3333_3333, 5'd9);
        tick();
        idle();
        @(negedge clock);
        chk("post_v1new", 32'(bus.resp1_valid), 32'd1);
        chk("post_d1new", bus.resp1_data, 32'h3333_3333);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
